// File: rtl/riscv_run_seq_defs.sv
`default_nettype none
// ============================================================================
// riscv_run_seq_defs : shared state encodings and field widths for the run
//                      sequencer and its scan-register map.
// Revision 1.0
// ============================================================================
package riscv_run_seq_defs;

   localparam int RUN_CYCLE_W = 64;
   localparam int TIMEOUT_W   = 32;
   localparam int ELAPSED_W   = 64;
   localparam int SEQ_CNT_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RESET_CORE = 3'd1,
      ST_ENABLE     = 3'd2,
      ST_RUN        = 3'd3,
      ST_DRAIN      = 3'd4,
      ST_DONE       = 3'd5
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_sat_counter.sv
`default_nettype none
// ============================================================================
// riscv_sat_counter : up-counter with synchronous clear that sticks at all-ones.
// Revision 1.0
// ============================================================================
module riscv_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/riscv_run_sequencer.sv
`default_nettype none
// ============================================================================
// riscv_run_sequencer : start / reset / enable / run / drain sequencing for the
//                       RISC-V clock-control stage, with elapsed-cycle report.
// Revision 1.0
// ============================================================================
module riscv_run_sequencer
   import riscv_run_seq_defs::*;
#(
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int DRAIN_CYCLES      = 2
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   seq_start,
   input  logic                   seq_abort,
   input  logic                   cfg_primary_en,
   input  logic                   cfg_secondary_en,
   input  logic                   cfg_reset_core,
   input  logic [RUN_CYCLE_W-1:0] cfg_run_cycle,
   input  logic                   cfg_run_cycle_enable,
   input  logic [TIMEOUT_W-1:0]   cfg_timeout,
   input  logic                   riscv_run_done_primary,
   input  logic                   riscv_run_done_secondary,
   output logic                   clk_en_in_primary,
   output logic                   clk_en_in_secondary,
   output logic                   primary_resetb,
   output logic                   secondary_resetb,
   output logic [RUN_CYCLE_W-1:0] riscv_run_cycle,
   output logic                   riscv_run_cycle_enable,
   output logic                   seq_busy,
   output logic                   seq_done,
   output logic                   seq_timeout,
   output logic                   seq_aborted,
   output logic [ELAPSED_W-1:0]   run_elapsed
);

   localparam logic [SEQ_CNT_W-1:0] HOLD_LAST  = SEQ_CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [SEQ_CNT_W-1:0] DRAIN_LAST = SEQ_CNT_W'(DRAIN_CYCLES - 1);

   seq_state_e             state_q, state_d;
   logic                   pri_en_q, pri_en_d, sec_en_q, sec_en_d;
   logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
   logic [RUN_CYCLE_W-1:0] run_cycle_q, run_cycle_d;
   logic                   run_cycle_en_q, run_cycle_en_d;
   logic                   clk_en_p_q, clk_en_p_d, clk_en_s_q, clk_en_s_d;
   logic                   rstb_p_q, rstb_p_d, rstb_s_q, rstb_s_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   timeout_q, timeout_d, aborted_q, aborted_d;

   logic                   elapsed_clr;
   logic [ELAPSED_W-1:0]   elapsed;
   logic [SEQ_CNT_W-1:0]   phase_cnt;
   logic                   all_done, timeout_hit;

   // A core that is not part of this run never holds the exit back.
   assign all_done    = (!pri_en_q || riscv_run_done_primary) &&
                        (!sec_en_q || riscv_run_done_secondary);
   assign timeout_hit = (tmo_q != '0) &&
                        ((elapsed + ELAPSED_W'(1)) == {{(ELAPSED_W-TIMEOUT_W){1'b0}}, tmo_q});

   always_comb begin
      state_d        = state_q;
      pri_en_d       = pri_en_q;
      sec_en_d       = sec_en_q;
      tmo_d          = tmo_q;
      run_cycle_d    = run_cycle_q;
      run_cycle_en_d = run_cycle_en_q;
      clk_en_p_d     = clk_en_p_q;
      clk_en_s_d     = clk_en_s_q;
      rstb_p_d       = rstb_p_q;
      rstb_s_d       = rstb_s_q;
      done_d         = 1'b0;
      timeout_d      = timeout_q;
      aborted_d      = aborted_q;
      elapsed_clr    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (seq_start) begin
               timeout_d = 1'b0;
               aborted_d = 1'b0;
               if (cfg_primary_en || cfg_secondary_en) begin
                  pri_en_d       = cfg_primary_en;
                  sec_en_d       = cfg_secondary_en;
                  tmo_d          = cfg_timeout;
                  run_cycle_d    = cfg_run_cycle;
                  run_cycle_en_d = cfg_run_cycle_enable;
                  elapsed_clr    = 1'b1;
                  if (cfg_reset_core) begin
                     state_d = ST_RESET_CORE;
                     if (cfg_primary_en)   rstb_p_d = 1'b0;
                     if (cfg_secondary_en) rstb_s_d = 1'b0;
                  end else begin
                     state_d = ST_ENABLE;
                     if (cfg_primary_en)   rstb_p_d = 1'b1;
                     if (cfg_secondary_en) rstb_s_d = 1'b1;
                  end
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RESET_CORE: begin
            if (seq_abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
            end else if (phase_cnt == HOLD_LAST) begin
               state_d = ST_ENABLE;
               if (pri_en_q) rstb_p_d = 1'b1;
               if (sec_en_q) rstb_s_d = 1'b1;
            end
         end
         ST_ENABLE: begin
            if (seq_abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
            end else begin
               state_d    = ST_RUN;
               clk_en_p_d = pri_en_q;
               clk_en_s_d = sec_en_q;
            end
         end
         ST_RUN: begin
            if (all_done || timeout_hit || seq_abort) begin
               state_d    = ST_DRAIN;
               clk_en_p_d = 1'b0;
               clk_en_s_d = 1'b0;
               if (!all_done) begin
                  if (timeout_hit) timeout_d = 1'b1;
                  else             aborted_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (phase_cnt == DRAIN_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q        <= ST_IDLE;
         pri_en_q       <= 1'b0;
         sec_en_q       <= 1'b0;
         tmo_q          <= '0;
         run_cycle_q    <= '0;
         run_cycle_en_q <= 1'b0;
         clk_en_p_q     <= 1'b0;
         clk_en_s_q     <= 1'b0;
         rstb_p_q       <= 1'b0;
         rstb_s_q       <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         timeout_q      <= 1'b0;
         aborted_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         pri_en_q       <= pri_en_d;
         sec_en_q       <= sec_en_d;
         tmo_q          <= tmo_d;
         run_cycle_q    <= run_cycle_d;
         run_cycle_en_q <= run_cycle_en_d;
         clk_en_p_q     <= clk_en_p_d;
         clk_en_s_q     <= clk_en_s_d;
         rstb_p_q       <= rstb_p_d;
         rstb_s_q       <= rstb_s_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         timeout_q      <= timeout_d;
         aborted_q      <= aborted_d;
      end
   end

   riscv_sat_counter #(.WIDTH(ELAPSED_W)) u_elapsed_cnt (
      .clk     (clk),
      .rst_n   (resetb),
      .clear_i (elapsed_clr),
      .en_i    (state_q == ST_RUN),
      .count_o (elapsed)
   );

   // Shared between the reset hold and the drain; restarts on every state change.
   riscv_sat_counter #(.WIDTH(SEQ_CNT_W)) u_phase_cnt (
      .clk     (clk),
      .rst_n   (resetb),
      .clear_i (state_d != state_q),
      .en_i    ((state_q == ST_RESET_CORE) || (state_q == ST_DRAIN)),
      .count_o (phase_cnt)
   );

   assign clk_en_in_primary      = clk_en_p_q;
   assign clk_en_in_secondary    = clk_en_s_q;
   assign primary_resetb         = rstb_p_q;
   assign secondary_resetb       = rstb_s_q;
   assign riscv_run_cycle        = run_cycle_q;
   assign riscv_run_cycle_enable = run_cycle_en_q;
   assign seq_busy               = busy_q;
   assign seq_done               = done_q;
   assign seq_timeout            = timeout_q;
   assign seq_aborted            = aborted_q;
   assign run_elapsed            = elapsed;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_sequencer.sv
`default_nettype none
// Scoreboard bench for riscv_run_sequencer: a run-level model predicts each
// completion report; a monitor checks it whenever seq_done pulses.
module tb_riscv_run_sequencer;

   localparam int H   = 16;
   localparam int D   = 2;
   localparam int INF = 1 << 30;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic        seq_start = 1'b0, seq_abort = 1'b0;
   logic        cfg_primary_en = 1'b0, cfg_secondary_en = 1'b0, cfg_reset_core = 1'b0;
   logic [63:0] cfg_run_cycle = '0;
   logic        cfg_run_cycle_enable = 1'b0;
   logic [31:0] cfg_timeout = '0;
   logic        done_p = 1'b0, done_s = 1'b0;

   logic        clk_en_in_primary, clk_en_in_secondary, primary_resetb, secondary_resetb;
   logic [63:0] riscv_run_cycle;
   logic        riscv_run_cycle_enable, seq_busy, seq_done, seq_timeout, seq_aborted;
   logic [63:0] run_elapsed;

   riscv_run_sequencer #(.RESET_HOLD_CYCLES(H), .DRAIN_CYCLES(D)) dut (
      .clk                      (clk),
      .resetb                   (resetb),
      .seq_start                (seq_start),
      .seq_abort                (seq_abort),
      .cfg_primary_en           (cfg_primary_en),
      .cfg_secondary_en         (cfg_secondary_en),
      .cfg_reset_core           (cfg_reset_core),
      .cfg_run_cycle            (cfg_run_cycle),
      .cfg_run_cycle_enable     (cfg_run_cycle_enable),
      .cfg_timeout              (cfg_timeout),
      .riscv_run_done_primary   (done_p),
      .riscv_run_done_secondary (done_s),
      .clk_en_in_primary        (clk_en_in_primary),
      .clk_en_in_secondary      (clk_en_in_secondary),
      .primary_resetb           (primary_resetb),
      .secondary_resetb         (secondary_resetb),
      .riscv_run_cycle          (riscv_run_cycle),
      .riscv_run_cycle_enable   (riscv_run_cycle_enable),
      .seq_busy                 (seq_busy),
      .seq_done                 (seq_done),
      .seq_timeout              (seq_timeout),
      .seq_aborted              (seq_aborted),
      .run_elapsed              (run_elapsed)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [63:0] el;
      logic        to;
      logic        ab;
      logic        busy;
      logic        pr;
      logic        sr;
      logic [63:0] rc;
      logic        rce;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad = 0;
   logic        m_pr = 1'b0, m_sr = 1'b0, m_rce = 1'b0;
   logic [63:0] m_el = '0, m_rc = '0;
   logic        pulse_chk = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every seq_done must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (pulse_chk) begin
         chk("done_pulse_width", 64'(seq_done), 64'd0);
         pulse_chk = 1'b0;
      end
      if (resetb && seq_done) begin
         pulse_chk = 1'b1;
         if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            chk("done_cycle",    64'(cyc), 64'(x.cyc));
            chk("run_elapsed",   run_elapsed, x.el);
            chk("seq_timeout",   64'(seq_timeout), 64'(x.to));
            chk("seq_aborted",   64'(seq_aborted), 64'(x.ab));
            chk("busy_at_done",  64'(seq_busy), 64'(x.busy));
            chk("clken_at_done", 64'({clk_en_in_primary, clk_en_in_secondary}), 64'd0);
            chk("prim_resetb",   64'(primary_resetb), 64'(x.pr));
            chk("sec_resetb",    64'(secondary_resetb), 64'(x.sr));
            chk("run_cycle",     riscv_run_cycle, x.rc);
            chk("run_cycle_en",  64'(riscv_run_cycle_enable), 64'(x.rce));
         end
      end
   end

   task automatic clear_inputs();
      seq_start = 1'b0; seq_abort = 1'b0; done_p = 1'b0; done_s = 1'b0;
      cfg_primary_en = 1'b0; cfg_secondary_en = 1'b0; cfg_reset_core = 1'b0;
      cfg_timeout = '0; cfg_run_cycle = '0; cfg_run_cycle_enable = 1'b0;
   endtask

   // dp/ds: RUN cycle (1 = first edge after enables rise) at which done is
   // sampled high, 0 = never. a: abort sampled at that RUN cycle, 0 = none.
   // j: abort during reset hold at that hold cycle, 0 = none.
   task automatic run(input bit pe, input bit se, input bit rc, input int t,
                      input int dp, input int ds, input int a, input int j, input bit noise);
      exp_t        x;
      int          n, e0, k, kd, sv, exit_e, done_c;
      logic        pr0, sr0;
      logic [63:0] rcv;
      logic        rcev;
      rcv  = {$urandom, $urandom};
      rcev = 1'($urandom);
      @(negedge clk);
      cfg_primary_en = pe; cfg_secondary_en = se; cfg_reset_core = rc;
      cfg_timeout = 32'(t); cfg_run_cycle = rcv; cfg_run_cycle_enable = rcev;
      seq_start = 1'b1;
      n   = cyc + 1;
      pr0 = m_pr;
      sr0 = m_sr;
      if (!pe && !se) begin
         x.cyc = n; x.el = m_el; x.to = 1'b0; x.ab = 1'b0; x.busy = 1'b0;
         x.pr = m_pr; x.sr = m_sr; x.rc = m_rc; x.rce = m_rce;
         sbq.push_back(x);
         @(negedge clk);
         clear_inputs();
         chk("empty_busy", 64'(seq_busy), 64'd0);
         @(negedge clk);
         chk("sb_drained", 64'(sbq.size()), 64'd0);
         sbq.delete();
         return;
      end
      e0 = rc ? n + H + 1 : n + 1;
      if (rc && j != 0) begin
         exit_e = n + j;
         x.el = '0; x.to = 1'b0; x.ab = 1'b1;
         x.pr = pe ? 1'b0 : m_pr;
         x.sr = se ? 1'b0 : m_sr;
      end else begin
         kd = pe ? ((dp == 0) ? INF : dp) : 1;
         if (se) begin
            sv = (ds == 0) ? INF : ds;
            if (sv > kd) kd = sv;
         end
         k = kd; x.to = 1'b0; x.ab = 1'b0;
         if (t != 0 && t < k) begin k = t; x.to = 1'b1; end
         if (a != 0 && a < k) begin k = a; x.to = 1'b0; x.ab = 1'b1; end
         exit_e = e0 + k;
         x.el = 64'(k);
         x.pr = pe ? 1'b1 : m_pr;
         x.sr = se ? 1'b1 : m_sr;
      end
      done_c = exit_e + D;
      x.cyc = done_c; x.busy = 1'b1; x.rc = rcv; x.rce = rcev;
      sbq.push_back(x);
      m_pr = x.pr; m_sr = x.sr; m_el = x.el; m_rc = rcv; m_rce = rcev;

      for (int e = n + 1; e <= done_c + 1; e++) begin
         @(negedge clk);
         seq_start = (noise && e <= done_c) ? 1'($urandom) : 1'b0;
         if (noise) begin
            cfg_primary_en = 1'($urandom); cfg_secondary_en = 1'($urandom);
            cfg_reset_core = 1'($urandom); cfg_timeout = $urandom;
            cfg_run_cycle = {$urandom, $urandom}; cfg_run_cycle_enable = 1'($urandom);
         end
         done_p = pe ? (dp != 0 && e >= e0 + dp) : (noise ? 1'($urandom) : 1'b0);
         done_s = se ? (ds != 0 && e >= e0 + ds) : (noise ? 1'($urandom) : 1'b0);
         seq_abort = (a != 0 && e == e0 + a) || (j != 0 && e == n + j) ||
                     (noise && e > exit_e && 1'($urandom));
         if (e - 1 == n) begin
            chk("busy_after_start", 64'(seq_busy), 64'd1);
            chk("prst_after_start", 64'(primary_resetb), 64'(pe ? !rc : pr0));
            chk("srst_after_start", 64'(secondary_resetb), 64'(se ? !rc : sr0));
         end
         if (!(rc && j != 0)) begin
            if (e - 1 == e0 - 1) chk("clken_before_rise", 64'({clk_en_in_primary, clk_en_in_secondary}), 64'd0);
            if (e - 1 == e0)     chk("clken_rise", 64'({clk_en_in_primary, clk_en_in_secondary}), 64'({pe, se}));
            if (rc && e - 1 == n + H - 1)
               chk("rst_hold_end", 64'({primary_resetb, secondary_resetb}), 64'({pe ? 1'b0 : pr0, se ? 1'b0 : sr0}));
            if (rc && e - 1 == n + H)
               chk("rst_release", 64'({primary_resetb, secondary_resetb}), 64'({pe ? 1'b1 : pr0, se ? 1'b1 : sr0}));
         end
         if (e - 1 == exit_e) chk("clken_drop", 64'({clk_en_in_primary, clk_en_in_secondary}), 64'd0);
      end
      @(negedge clk);
      clear_inputs();
      chk("sb_drained", 64'(sbq.size()), 64'd0);
      sbq.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({clk_en_in_primary, clk_en_in_secondary, primary_resetb, secondary_resetb,
                              riscv_run_cycle_enable, seq_busy, seq_done, seq_timeout, seq_aborted}), 64'd0);
      chk({tag, "_run_cycle"}, riscv_run_cycle, 64'd0);
      chk({tag, "_elapsed"}, run_elapsed, 64'd0);
   endtask

   task automatic reset_mid_run();
      @(negedge clk);
      cfg_primary_en = 1'b1; cfg_secondary_en = 1'b1; cfg_reset_core = 1'b0;
      cfg_timeout = '0; cfg_run_cycle = 64'h1234; seq_start = 1'b1;
      @(negedge clk);
      clear_inputs();
      repeat (10) @(negedge clk);
      chk("mid_run_busy", 64'(seq_busy), 64'd1);
      chk("mid_run_clken", 64'({clk_en_in_primary, clk_en_in_secondary}), 64'd3);
      #2 resetb = 1'b0;
      #1 check_all_zero("async_reset");
      m_pr = 1'b0; m_sr = 1'b0; m_el = '0; m_rc = '0; m_rce = 1'b0;
      @(negedge clk);
      resetb = 1'b1;
   endtask

   initial begin
      int pe, se, rc, t, dp, ds, a, j;
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      resetb = 1'b1;
      @(negedge clk);
      check_all_zero("after_release");

      run(1, 0, 0, 0, 100, 0, 0, 0, 0);   // primary only, done at 100
      run(1, 1, 1, 0, 80, 50, 0, 0, 0);   // both cores with reset pulse
      run(1, 0, 0, 10, 0, 0, 0, 0, 0);    // timeout
      run(1, 0, 0, 0, 30, 0, 30, 0, 0);   // done and abort together
      run(0, 0, 0, 0, 0, 0, 0, 0, 0);     // nothing enabled
      run(1, 1, 1, 0, 20, 20, 0, 5, 0);   // abort during reset hold
      run(0, 1, 0, 7, 0, 0, 7, 0, 0);     // timeout and abort together
      reset_mid_run();
      run(1, 1, 0, 0, 15, 25, 0, 0, 0);

      for (int r = 0; r < 30; r++) begin
         pe = int'($urandom_range(0, 1));
         se = int'($urandom_range(0, 1));
         rc = int'($urandom_range(0, 1));
         t  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
         dp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
         ds = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
         a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
         j  = (rc != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, H - 1)) : 0;
         if (((pe != 0 && dp == 0) || (se != 0 && ds == 0)) && t == 0 && a == 0) t = 70;
         run(pe[0], se[0], rc[0], t, dp, ds, a, j, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
